// File: rtl/usb_arb_pkg.sv
// ---------------------------------------------------------------------------
// usb_arb_pkg
// Shared definitions for the USB IN-endpoint arbiter:
//   state_t   - arbiter FSM states (IDLE, HDR, DATA)
//   HDR_TAG   - upper nibble of the per-burst header byte
//   build_hdr - builds the header byte {HDR_TAG, 2'b00, id}
// ---------------------------------------------------------------------------
package usb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic logic [7:0] build_hdr(input logic [1:0] id);
    return {HDR_TAG, 2'b00, id};
  endfunction

endpackage

// File: rtl/usb_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// usb_arb_rr_pick
// Combinational round-robin picker: selects the first asserted bit of
// 'valid' at or after index 'ptr', wrapping modulo NUM_REQ.
// Ports:
//   valid [NUM_REQ-1:0] - request vector
//   ptr   [1:0]         - search start index (must be < NUM_REQ)
//   grant [NUM_REQ-1:0] - one-hot winner, zero when nothing is valid
//   id    [1:0]         - binary index of the winner
//   any                 - at least one request is valid
// ---------------------------------------------------------------------------
module usb_arb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         id,
  output logic               any
);

  // NOTE: every output gets a default before the search so the block stays
  // purely combinational; a path that leaves a variable unassigned would
  // infer a latch.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    // Outer loop walks the priority order starting at ptr; the inner loop
    // keeps every bit select at a constant index.
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && valid[j] && (j == (int'(ptr) + i) % NUM_REQ)) begin
          grant[j] = 1'b1;
          id       = 2'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_in_arb.sv
// ---------------------------------------------------------------------------
// usb_in_arb
// Round-robin arbiter that merges up to four byte streams into one USB CDC
// IN stream. Each grant emits one header byte {4'hA, 2'b00, id} followed by
// up to MAX_BURST data bytes passed straight through from the owner. A
// burst ends on the owner's last byte, on the MAX_BURST-th byte, or after
// TIMEOUT consecutive cycles in which the owner has nothing to send.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   configured_i  - device configured; gates new grants only
//   req_data_i    - requester k byte at [8k+7:8k]
//   req_valid_i   - per-requester byte valid
//   req_last_i    - per-requester end-of-message, qualified by valid
//   req_ready_o   - per-requester byte accepted
//   in_data_o     - byte to the IN stream
//   in_valid_o    - IN byte valid
//   in_ready_i    - IN stream ready
//   grant_o       - one-hot current owner, zero when idle
//   timeout_o     - one-cycle pulse on a timeout release
// ---------------------------------------------------------------------------
module usb_in_arb
  import usb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 configured_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 timeout_o
);

  localparam int             CW         = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [7:0]     IDLE_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0]     ID_MAX     = 2'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [1:0]           id_q;
  logic [1:0]           rr_ptr_q;
  logic [CW-1:0]        byte_cnt_q;
  logic [7:0]           idle_cnt_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [1:0]           pick_id;
  logic                 pick_any;

  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;

  logic                 start;
  logic                 accept;
  logic                 burst_done;
  logic                 idle_expire;
  logic [1:0]           ptr_next;

  usb_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  // Owner's stream, selected by the registered one-hot grant.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data  = req_data_i[8*k +: 8];
        sel_valid = req_valid_i[k];
        sel_last  = req_last_i[k];
      end
    end
  end

  assign start       = (state_q == ST_IDLE) && configured_i && pick_any;
  assign accept      = (state_q == ST_DATA) && sel_valid && in_ready_i;
  // Last flag and burst limit on the same byte collapse into one end.
  assign burst_done  = accept && (sel_last || (byte_cnt_q == BURST_LAST));
  // A stalled byte (valid high, ready low) keeps the idle counter cleared.
  assign idle_expire = (state_q == ST_DATA) && !sel_valid && (idle_cnt_q == IDLE_LAST);
  assign ptr_next    = (id_q == ID_MAX) ? 2'd0 : id_q + 2'd1;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Losing configured_i mid-burst does not abort; it only
  // blocks the IDLE -> HDR transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                     state_d = ST_HDR;
      ST_HDR:  if (in_ready_i)                state_d = ST_DATA;
      ST_DATA: if (burst_done || idle_expire) state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Grant, pointer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            grant_q    <= pick_grant;
            id_q       <= pick_id;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (accept)    byte_cnt_q <= byte_cnt_q + CW'(1);
          if (sel_valid) idle_cnt_q <= '0;
          else           idle_cnt_q <= idle_cnt_q + 8'd1;
          if (burst_done || idle_expire) begin
            grant_q  <= '0;
            rr_ptr_q <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    in_valid_o  = 1'b0;
    in_data_o   = '0;
    req_ready_o = '0;
    timeout_o   = 1'b0;
    case (state_q)
      ST_HDR: begin
        in_valid_o = 1'b1;
        in_data_o  = build_hdr(id_q);
      end
      ST_DATA: begin
        in_valid_o  = sel_valid;
        in_data_o   = sel_data;
        req_ready_o = grant_q & {NUM_REQ{in_ready_i}};
        timeout_o   = idle_expire;
      end
      default: ;
    endcase
  end

  assign grant_o = grant_q;

endmodule
